pg_skid_stage: RTL and testbench

PG_SKID_STAGE -- requirements
Module: pg_skid_stage

---
 rtl/pg_pkg.sv | 16 +
 rtl/pg_cell.sv | 17 +
 rtl/pg_skid_stage.sv | 127 ++++++++++++
 tb/tb_pg_skid_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pg_pkg.sv
// Shared definitions for the generate/propagate skid stage.
// Holds the occupancy state encoding and the handshake counter width.
// No logic lives here; combinational helpers stay in their own modules.
package pg_pkg;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pg_state_t;

  // Width of the completed-output-handshake counter.
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/pg_cell.sv
// Per-bit generate/propagate cell: g = a & b, p = a ^ b.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it has no state and no handshake.
// Ports: a, b operands in; g, p per-bit generate/propagate out.
module pg_cell #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] p
);

  assign g = a & b;
  assign p = a ^ b;

endmodule

// File: rtl/pg_skid_stage.sv
// Registered G/P stage with a two-entry skid buffer between valid/ready ports.
// Latency: one cycle from input handshake to out_valid; full rate when out_ready=1.
// Backpressure: in_ready is a flop that drops only when both entries are held.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_a/in_b/in_cin
//        upstream; out_valid/out_ready/out_g/out_p/out_cin downstream;
//        out_count counts completed output handshakes (wraps).
module pg_skid_stage
  import pg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_g,
  output logic [WIDTH-1:0] out_p,
  output logic             out_cin,
  output logic [CNT_W-1:0] out_count
);

  pg_state_t         state_q, state_d;
  logic              in_ready_q, out_valid_q;
  logic [WIDTH-1:0]  head_g_q, head_p_q, skid_g_q, skid_p_q;
  logic              head_cin_q, skid_cin_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [WIDTH-1:0]  cap_g, cap_p;
  logic              in_hs, out_hs;
  logic              load_head_new, load_head_skid, load_skid;

  // G/P is formed at capture so only registered words reach the outputs.
  pg_cell #(.WIDTH(WIDTH)) u_cell (
    .a (in_a),
    .b (in_b),
    .g (cap_g),
    .p (cap_p)
  );

  assign in_hs  = in_valid & in_ready_q;
  assign out_hs = out_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_hs) begin
          load_head_new = 1'b1;
          state_d       = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_hs && out_hs) begin
          // Head leaves and the new word takes its place in the same cycle.
          load_head_new = 1'b1;
        end else if (in_hs) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (out_hs) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so in_valid cannot complete a handshake.
        if (out_hs) begin
          load_head_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_g_q    <= '0;
      head_p_q    <= '0;
      head_cin_q  <= 1'b0;
      skid_g_q    <= '0;
      skid_p_q    <= '0;
      skid_cin_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      // Handshake flags are registered copies of the next-state decode, so
      // neither depends combinationally on out_ready.
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      if (load_head_new) begin
        head_g_q   <= cap_g;
        head_p_q   <= cap_p;
        head_cin_q <= in_cin;
      end else if (load_head_skid) begin
        head_g_q   <= skid_g_q;
        head_p_q   <= skid_p_q;
        head_cin_q <= skid_cin_q;
      end
      if (load_skid) begin
        skid_g_q   <= cap_g;
        skid_p_q   <= cap_p;
        skid_cin_q <= in_cin;
      end
      if (out_hs) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_g     = head_g_q;
  assign out_p     = head_p_q;
  assign out_cin   = head_cin_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_pg_skid_stage.sv
// Scoreboard bench for pg_skid_stage: directed scenarios plus random stalls.
// Expected words are queued at input handshake and popped at output handshake.
// Occupancy, ready/valid and counter are predicted from the queue itself.
module tb_pg_skid_stage;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic         cin;
  } word_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_g, out_p;
  logic         out_cin;
  logic [7:0]   out_count;

  int checks   = 0;
  int failures = 0;

  word_t sb[$];
  int    exp_cnt = 0;
  bit    mon_en  = 1'b0;

  // Previous-cycle snapshot for output-stability checks.
  bit           prev_ok = 1'b0;
  logic         prev_valid, prev_ready;
  logic [W-1:0] prev_g, prev_p;
  logic         prev_cin;

  pg_skid_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_g     (out_g),
    .out_p     (out_p),
    .out_cin   (out_cin),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    word_t w;
    w.g   = a & b;
    w.p   = a ^ b;
    w.cin = c;
    return w;
  endfunction

  // Monitor: samples on the falling edge, away from the capturing edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        sb.delete();
        exp_cnt = 0;
        prev_ok = 1'b0;
      end else begin
        chk("mon_out_valid", 64'(out_valid), 64'(sb.size() > 0));
        chk("mon_in_ready", 64'(in_ready), 64'(sb.size() < 2));
        chk("mon_out_count", 64'(out_count), 64'(exp_cnt % 256));
        if (prev_ok && ((prev_valid && !prev_ready) || (!prev_valid && !out_valid))) begin
          chk("mon_hold", {out_g, out_p, out_cin}, {prev_g, prev_p, prev_cin});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("mon_unexpected_word", 64'd1, 64'd0);
          end else begin
            word_t e;
            e = sb.pop_front();
            chk("mon_word", {out_g, out_p, out_cin}, e);
          end
          exp_cnt++;
        end
        if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_cin));
        prev_ok    = 1'b1;
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_g     = out_g;
        prev_p     = out_p;
        prev_cin   = out_cin;
      end
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      done = !out_valid;
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    word_t wy, wz;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_g", 64'(out_g), 64'd0);
    chk("rst_out_p", 64'(out_p), 64'd0);
    chk("rst_out_cin", 64'(out_cin), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    @(posedge clk); #1;

    // First word with downstream stalled.
    send(16'h00FF, 16'h0F0F, 1'b1);
    @(negedge clk);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_g", 64'(out_g), 64'h000F);
    chk("first_p", 64'(out_p), 64'h0FF0);
    chk("first_cin", 64'(out_cin), 64'd1);
    chk("first_count", 64'(out_count), 64'd0);
    @(posedge clk); #1;
    drain();

    // Three words into a stalled stage: third is held off until space frees.
    do_reset();
    out_ready = 1'b0;
    send(16'h0001, 16'h0003, 1'b0);
    send(16'h0002, 16'h0006, 1'b1);
    @(negedge clk);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_a     = 16'h0003;
    in_b     = 16'h0009;
    in_cin   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("held_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(16'h0003, 16'h0009, 1'b0);
    drain();
    chk("three_count", 64'(out_count), 64'd3);

    // 300 back-to-back words with out_ready held high.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_cin   = 1'($urandom);
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) chk("stream_no_bubble", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk("stream_count_wrap", 64'(out_count), 64'd44);

    // Simultaneous in/out handshake in ONE keeps one entry, head replaced.
    do_reset();
    out_ready = 1'b0;
    send(16'h1234, 16'h00FF, 1'b0);
    wy        = model(16'hA5A5, 16'hFF00, 1'b1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 16'hA5A5;
    in_b      = 16'hFF00;
    in_cin    = 1'b1;
    @(negedge clk);
    chk("swap_pre_valid", 64'(out_valid), 64'd1);
    chk("swap_pre_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("swap_in_ready", 64'(in_ready), 64'd1);
    chk("swap_head", {out_g, out_p, out_cin}, wy);
    chk("swap_count", 64'(out_count), 64'd1);
    @(posedge clk); #1;
    drain();
    chk("swap_count_end", 64'(out_count), 64'd2);

    // Reset while FULL discards both entries.
    do_reset();
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b1);
    send(16'h3333, 16'h4444, 1'b0);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 16'hDEAD;
    in_b      = 16'hBEEF;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("frst_out_valid", 64'(out_valid), 64'd0);
    chk("frst_in_ready", 64'(in_ready), 64'd1);
    chk("frst_count", 64'(out_count), 64'd0);
    chk("frst_data", {out_g, out_p, out_cin}, 64'd0);
    @(posedge clk); #1;
    wz = model(16'hC3C3, 16'h0FF0, 1'b1);
    send(16'hC3C3, 16'h0FF0, 1'b1);
    @(negedge clk);
    chk("post_rst_word", {out_g, out_p, out_cin}, wz);
    @(posedge clk); #1;
    drain();
    chk("post_rst_count", 64'(out_count), 64'd1);

    // Random valid/ready stalls.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_cin    = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk("random_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
